instruction_fetch_unit: RTL and testbench

Fetch stage that initiates requests to the instruction memory.
- Owns the PC register and drives the fetch address each cycle.
- Samples the memory's instruction word and its accept flag.
- Loads the IF/ID pipeline register.
- Handles stall, branch/jump redirect (including a redirect that arrives during a stall), exception entry and ERET return.
- Tags fetches the memory rejects with an address-error exception for CP0.

---
 rtl/ifu_pkg.sv | 8 +
 rtl/ifu_next_pc_sel.sv | 33 +++
 rtl/instruction_fetch_unit.sv | 100 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants and state type for the instruction fetch unit.
package ifu_pkg;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;
  localparam logic [31:0] NOP_WORD   = 32'h0;
  typedef enum logic {RUN, HOLD} ifu_state_e;
endpackage

// File: rtl/ifu_next_pc_sel.sv
// ifu_next_pc_sel: priority mux choosing the next PC, fetch state and pending-capture strobe.
module ifu_next_pc_sel
  import ifu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  ifu_state_e  state_i,
  input  logic [31:0] pending_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic        exc_req_i,
  input  logic        eret_req_i,
  input  logic [31:0] epc_i,
  output logic [31:0] next_pc_o,
  output ifu_state_e  next_state_o,
  output logic        capture_pending_o
);
  logic hold;
  always_comb begin
    hold = state_i == HOLD;
    // Only the first redirect seen during a stall is kept; later ones are dropped.
    capture_pending_o = ~exc_req_i & ~eret_req_i & stall_i & ~hold & redirect_valid_i;
    next_pc_o = exc_req_i        ? HANDLER_PC :
                eret_req_i       ? epc_i :
                stall_i          ? pc_i :
                hold             ? pending_i :
                redirect_valid_i ? redirect_target_i :
                                   pc_i + 32'd4;
    next_state_o = (exc_req_i | eret_req_i) ? RUN :
                   stall_i                  ? ((hold | capture_pending_o) ? HOLD : RUN) :
                                              RUN;
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register, fetch address and IF/ID pipeline register.
// Optional IFU_BD_FLAG_EN adds the id_bd branch-delay flag output.
module instruction_fetch_unit
  import ifu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] im_pc,
  input  logic        im_accepted,
  input  logic [31:0] im_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_exc,
  output logic [4:0]  id_exccode
`ifdef IFU_BD_FLAG_EN
  ,
  output logic        id_bd
`endif
);
  logic [31:0] pc_q, pc_d, pending_q, pending_d;
  ifu_state_e  state_q, state_d;
  logic        capture;
  logic [31:0] id_pc_q, id_pc_d, id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d, id_exc_q, id_exc_d;
  logic [4:0]  id_exccode_q, id_exccode_d;
  logic        flush, load;

  ifu_next_pc_sel u_sel (
    .pc_i              (pc_q),
    .state_i           (state_q),
    .pending_i         (pending_q),
    .stall_i           (stall),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .exc_req_i         (exc_req),
    .eret_req_i        (eret_req),
    .epc_i             (epc),
    .next_pc_o         (pc_d),
    .next_state_o      (state_d),
    .capture_pending_o (capture)
  );

  always_comb begin
    flush        = exc_req | eret_req;
    load         = ~flush & ~stall;
    pending_d    = flush ? 32'h0 : capture ? redirect_target : pending_q;
    id_pc_d      = flush ? 32'h0 : load ? pc_q : id_pc_q;
    id_inst_d    = flush ? NOP_WORD : load ? im_inst : id_inst_q;
    id_valid_d   = flush ? 1'b0 : load ? 1'b1 : id_valid_q;
    id_exc_d     = flush ? 1'b0 : load ? ~im_accepted : id_exc_q;
    id_exccode_d = flush ? 5'd0 : load ? (im_accepted ? 5'd0 : EXC_ADEL) : id_exccode_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      state_q      <= RUN;
      pending_q    <= 32'h0;
      id_pc_q      <= 32'h0;
      id_inst_q    <= 32'h0;
      id_valid_q   <= 1'b0;
      id_exc_q     <= 1'b0;
      id_exccode_q <= 5'd0;
    end else begin
      pc_q         <= pc_d;
      state_q      <= state_d;
      pending_q    <= pending_d;
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
      id_valid_q   <= id_valid_d;
      id_exc_q     <= id_exc_d;
      id_exccode_q <= id_exccode_d;
    end
  end

`ifdef IFU_BD_FLAG_EN
  logic id_bd_q, id_bd_d;
  // A load in the cycle a redirect takes effect marks the delay-slot instruction.
  assign id_bd_d = flush ? 1'b0 : load ? ((state_q == HOLD) | redirect_valid) : id_bd_q;
  always_ff @(posedge clk) begin
    if (reset) id_bd_q <= 1'b0;
    else id_bd_q <= id_bd_d;
  end
  assign id_bd = id_bd_q;
`endif

  assign im_pc      = pc_q;
  assign id_pc      = id_pc_q;
  assign id_inst    = id_inst_q;
  assign id_valid   = id_valid_q;
  assign id_exc     = id_exc_q;
  assign id_exccode = id_exccode_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized scoreboard bench with a behavioural fetch model.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, redirect_valid = 1'b0, exc_req = 1'b0, eret_req = 1'b0;
  logic [31:0] redirect_target = '0, epc = '0;
  logic [31:0] im_pc, im_inst, id_pc, id_inst;
  logic        im_accepted, id_valid, id_exc;
  logic [4:0]  id_exccode;
`ifdef IFU_BD_FLAG_EN
  logic        id_bd;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_exc;
    logic [4:0]  id_exccode;
    logic        id_bd;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state
  logic [31:0] m_pc = 32'h3000, m_tgt = '0;
  bit          m_hold = 0;
  exp_t        m_id = '0;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .im_pc(im_pc), .im_accepted(im_accepted), .im_inst(im_inst),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
    .id_exc(id_exc), .id_exccode(id_exccode)
`ifdef IFU_BD_FLAG_EN
    , .id_bd(id_bd)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit mem_ok(input logic [31:0] a);
    return a[1:0] == 2'b00 && a < 32'h0000_8000;
  endfunction
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_ok(a) ? {a[15:0], ~a[15:0]} : 32'h0;
  endfunction

  assign im_accepted = mem_ok(im_pc);
  assign im_inst     = mem_word(im_pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances and its expected post-edge view is queued.
  task automatic cyc(input bit r, input bit st, input bit rv, input logic [31:0] rt,
                     input bit ex, input bit er, input logic [31:0] ep);
    exp_t e;
    @(negedge clk);
    reset = r; stall = st; redirect_valid = rv; redirect_target = rt;
    exc_req = ex; eret_req = er; epc = ep;
    if (r) begin
      m_pc = 32'h3000; m_hold = 0; m_tgt = 0; m_id = '0;
    end else begin
      if (ex || er) m_id = '0;
      else if (!st) begin
        m_id.id_pc      = m_pc;
        m_id.id_inst    = mem_word(m_pc);
        m_id.id_valid   = 1;
        m_id.id_exc     = !mem_ok(m_pc);
        m_id.id_exccode = mem_ok(m_pc) ? 5'd0 : 5'd4;
        m_id.id_bd      = m_hold || rv;
      end
      if (ex) begin m_pc = 32'h4180; m_hold = 0; m_tgt = 0; end
      else if (er) begin m_pc = ep; m_hold = 0; m_tgt = 0; end
      else if (st) begin
        if (!m_hold && rv) begin m_hold = 1; m_tgt = rt; end
      end
      else if (m_hold) begin m_pc = m_tgt; m_hold = 0; end
      else if (rv) m_pc = rt;
      else m_pc = m_pc + 32'd4;
    end
    e = m_id;
    e.pc = m_pc;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("im_pc", im_pc, e.pc);
      chk("id_pc", id_pc, e.id_pc);
      chk("id_inst", id_inst, e.id_inst);
      chk("id_valid", {31'b0, id_valid}, {31'b0, e.id_valid});
      chk("id_exc", {31'b0, id_exc}, {31'b0, e.id_exc});
      chk("id_exccode", {27'b0, id_exccode}, {27'b0, e.id_exccode});
`ifdef IFU_BD_FLAG_EN
      chk("id_bd", {31'b0, id_bd}, {31'b0, e.id_bd});
`endif
    end
  end

  function automatic logic [31:0] rand_addr();
    int k = $urandom_range(0, 9);
    if (k == 0) return $urandom;
    if (k == 1) return 32'h3000 + ($urandom_range(0, 255) << 2) + $urandom_range(1, 3);
    return 32'h3000 + ($urandom_range(0, 1023) << 2);
  endfunction

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h3100, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h3200, 0, 0, 0);
    cyc(0, 1, 1, 32'h3300, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h3002, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 1, 32'h3044);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h3500, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h3040);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h3600, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (3000)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          rand_addr(), $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0, rand_addr());
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
